// File: rtl/simon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_pkg : Simon128/256 constants, controller states, round f()   |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package simon_pkg;

    localparam int ROUNDS  = 72;
    localparam int KEY_LAT = 2;
    localparam int WORD    = 64;
    localparam int ADDR_W  = 9;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned s);
        return (v << s) | (v >> (WORD - s));
    endfunction

    function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_round : one combinational Simon round, encrypt or decrypt    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module simon_round
    import simon_pkg::*;
(
    input  logic                i_decrypt,
    input  logic [2*WORD-1:0]   i_block,
    input  logic [WORD-1:0]     i_key,
    output logic [2*WORD-1:0]   o_block
);

    logic [WORD-1:0] w_x;
    logic [WORD-1:0] w_y;

    assign w_x = i_block[2*WORD-1:WORD];
    assign w_y = i_block[WORD-1:0];

    // Decrypt is the exact inverse of encrypt, so subkeys must arrive reversed
    always_comb begin
        if (i_decrypt) begin
            o_block = {w_y, w_x ^ simon_f(w_y) ^ i_key};
        end else begin
            o_block = {w_y ^ simon_f(w_x) ^ i_key, w_x};
        end
    end

endmodule
`default_nettype wire

// File: rtl/simon_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_round_ctrl : sequences one Simon128/256 block op over the    |
// | subkey memory read port.   Revision : 1.0                          |
// +--------------------------------------------------------------------+
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int ROUNDS  = simon_pkg::ROUNDS,
    parameter int KEY_LAT = simon_pkg::KEY_LAT,
    parameter int WORD    = simon_pkg::WORD,
    parameter int ADDR_W  = simon_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [2*WORD-1:0]   in_block,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*WORD-1:0]   out_block,
    output logic                abort_err,
    input  logic                key_compute_start,
    input  logic                key_mem_full,
    output logic                key_rd_en,
    output logic [ADDR_W-1:0]   key_addr,
    input  logic [WORD-1:0]     key_data,
    input  logic                key_data_vld
);

    localparam int              DROP_W = $clog2(KEY_LAT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ROUNDS);

    state_t             state_q, state_d;
    logic [WORD-1:0]    x_q, x_d, y_q, y_d;
    logic               dec_q, dec_d;
    logic [CNT_W-1:0]   issue_q, issue_d, rcv_q, rcv_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               keys_ok_q, keys_ok_d;
    logic               abort_q, abort_d;

    logic               w_accept;
    logic               w_abort;
    logic               w_take;
    logic [CNT_W-1:0]   w_idx;
    logic [2*WORD-1:0]  w_round;

    assign w_accept = in_valid && in_ready;
    assign w_abort  = key_compute_start && (state_q != IDLE);
    // Returns still in flight from an aborted op are swallowed by drop_q
    assign w_take   = key_data_vld && (drop_q == '0) &&
                      ((state_q == RUN) || (state_q == DRAIN));

    simon_round u_round (
        .i_decrypt (dec_q),
        .i_block   ({x_q, y_q}),
        .i_key     (key_data),
        .o_block   (w_round)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            dec_q     <= 1'b0;
            issue_q   <= '0;
            rcv_q     <= '0;
            drop_q    <= '0;
            keys_ok_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            dec_q     <= dec_d;
            issue_q   <= issue_d;
            rcv_q     <= rcv_d;
            drop_q    <= drop_d;
            keys_ok_q <= keys_ok_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        keys_ok_d = keys_ok_q;
        if (key_compute_start) begin
            keys_ok_d = 1'b0;
        end else if (key_mem_full) begin
            keys_ok_d = 1'b1;
        end

        x_d     = x_q;
        y_d     = y_q;
        dec_d   = dec_q;
        issue_d = issue_q;
        rcv_d   = rcv_q;
        abort_d = w_abort;
        drop_d  = (drop_q != '0) ? drop_q - 1'b1 : drop_q;
        if (w_abort) begin
            drop_d = DROP_W'(KEY_LAT);
        end

        if (w_accept) begin
            {x_d, y_d} = in_block;
            dec_d      = in_decrypt;
            issue_d    = '0;
            rcv_d      = '0;
        end
        if ((state_q == RUN) && (issue_q != LAST)) begin
            issue_d = issue_q + 1'b1;
        end
        if (w_take) begin
            {x_d, y_d} = w_round;
            if (rcv_q != LAST) begin
                rcv_d = rcv_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = RUN;
            RUN:     if (issue_q == LAST - 1'b1) state_d = DRAIN;
            DRAIN:   if (rcv_d == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (w_abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        w_idx     = dec_q ? (LAST - 1'b1 - issue_q) : issue_q;
        in_ready  = (state_q == IDLE) && keys_ok_q && !key_compute_start;
        key_rd_en = (state_q == RUN);
        key_addr  = (state_q == RUN) ? ADDR_W'(w_idx) : '0;
        // An abort arriving in DONE must not let the dropped result be taken
        out_valid = (state_q == DONE) && !key_compute_start;
        out_block = (state_q == DONE) ? {x_q, y_q} : '0;
        abort_err = abort_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_simon_round_ctrl : scoreboard bench with Simon128/256 model     |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_simon_round_ctrl;

    localparam logic [255:0] KAT_KEY = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h74206e69206d6f6f_6d69732061207369;
    localparam logic [127:0] KAT_CT  = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

    bit           clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_decrypt;
    logic [127:0] in_block;
    logic         out_valid, out_ready;
    logic [127:0] out_block;
    logic         abort_err;
    logic         key_compute_start, key_mem_full;
    logic         key_rd_en;
    logic [8:0]   key_addr;
    logic [63:0]  key_data;
    logic         key_data_vld;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int hs_cyc     = 0;
    bit ov_prev    = 1'b0;

    logic [127:0] exp_q[$];
    logic [8:0]   addr_q[$];
    logic [63:0]  sk[72];

    logic         p_vld0, p_vld1, junk_vld;
    logic [63:0]  p_d0, p_d1, junk_word;

    simon_round_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_decrypt        (in_decrypt),
        .in_block          (in_block),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_block         (out_block),
        .abort_err         (abort_err),
        .key_compute_start (key_compute_start),
        .key_mem_full      (key_mem_full),
        .key_rd_en         (key_rd_en),
        .key_addr          (key_addr),
        .key_data          (key_data),
        .key_data_vld      (key_data_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Subkey memory with a two-cycle read latency
    always @(posedge clk) begin
        p_vld0 <= key_rd_en;
        p_d0   <= (key_addr < 9'd72) ? sk[key_addr] : 64'd0;
        p_vld1 <= p_vld0;
        p_d1   <= p_d0;
    end
    assign key_data_vld = p_vld1 | junk_vld;
    assign key_data     = junk_vld ? junk_word : p_d1;

    function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction
    function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction
    function automatic logic [63:0] fmix(input logic [63:0] v);
        return (rol64(v, 1) & rol64(v, 8)) ^ rol64(v, 2);
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] b);
        logic [63:0] x, y, t;
        x = b[127:64]; y = b[63:0];
        for (int i = 0; i < 72; i++) begin
            t = x; x = y ^ fmix(x) ^ sk[i]; y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] b);
        logic [63:0] x, y, t;
        x = b[127:64]; y = b[63:0];
        for (int i = 71; i >= 0; i--) begin
            t = y; y = x ^ fmix(y) ^ sk[i]; x = t;
        end
        return {x, y};
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [63:0] k[72];
        logic [63:0] tmp;
        logic [63:0] z;
        z = 64'h3DC94C3A046D678B;
        k[0] = key[63:0];    k[1] = key[127:64];
        k[2] = key[191:128]; k[3] = key[255:192];
        for (int i = 4; i < 72; i++) begin
            tmp  = ror64(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror64(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {63'd0, z[(i-4) % 62]} ^ 64'd3;
        end
        for (int i = 0; i < 72; i++) sk[i] = k[i];
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Scoreboard monitor: result blocks, subkey addresses, latency
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) hs_cyc = cyc;
            if (out_valid && !ov_prev) check("latency", 128'(cyc - hs_cyc), 128'd75);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected out_valid handshake");
                else check("out_block", out_block, exp_q.pop_front());
            end
            if (key_rd_en) begin
                if (addr_q.size() == 0) fail_now("spurious key_rd_en");
                else check("key_addr", 128'(key_addr), 128'(addr_q.pop_front()));
            end
        end
        ov_prev = out_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] blk, input bit dec, input logic [127:0] exp, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        in_block = blk; in_decrypt = dec; in_valid = 1'b1;
        while (waited < 400) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            waited++;
        end
        if (!ok) begin
            check("in_ready timeout", 128'(in_ready), 128'd1);
        end else begin
            exp_q.push_back(exp);
            for (int i = 0; i < 72; i++) addr_q.push_back(dec ? 9'(71 - i) : 9'(i));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_keys(input logic [255:0] key);
        int pulses;
        pulses = 0;
        key_compute_start = 1'b1;
        @(negedge clk);
        check("in_ready during start", 128'(in_ready), 128'd0);
        pulses += int'(abort_err);
        @(posedge clk); #1;
        key_compute_start = 1'b0;
        expand(key);
        repeat (3) begin
            @(negedge clk);
            check("in_ready keys stale", 128'(in_ready), 128'd0);
            pulses += int'(abort_err);
        end
        check("no abort_err for idle start", 128'(pulses), 128'd0);
        @(posedge clk); #1;
        key_mem_full = 1'b1;
        tick(1);
        key_mem_full = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain timeout", 128'(exp_q.size()), 128'd0);
        tick(1);
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        logic [127:0] b, e;
        bit           d;
        int           w, cnt_abort, cnt_ov, cnt_rdy, cnt_rd, bad;

        rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_block = '0;
        out_ready = 1'b1; key_compute_start = 1'b0; key_mem_full = 1'b0;
        junk_vld = 1'b0; junk_word = '0;
        #12;
        check("reset ctrl outputs", 128'({in_ready, out_valid, abort_err, key_rd_en, key_addr}), 128'd0);
        check("reset out_block", out_block, 128'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // No subkeys yet: in_valid must not be accepted
        expand(KAT_KEY);
        in_block = KAT_PT; in_decrypt = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("in_ready before full", 128'(in_ready), 128'd0);
            check("key_rd_en before full", 128'(key_rd_en), 128'd0);
        end
        @(posedge clk); #1;
        key_mem_full = 1'b1;
        @(negedge clk);
        check("in_ready in full cycle", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        key_mem_full = 1'b0;
        send(KAT_PT, 1'b0, KAT_CT, w);
        check("in_ready one cycle after full", 128'(w), 128'd0);
        wait_drain();

        // Stray key_data_vld while idle must not disturb the next block
        junk_word = 64'hdeadbeefcafef00d; junk_vld = 1'b1;
        tick(3);
        junk_vld = 1'b0;
        send(KAT_CT, 1'b1, KAT_PT, w);
        wait_drain();

        // Back-to-back random blocks, throughput 76 cycles
        for (int i = 0; i < 5; i++) begin
            b = rand_blk(); d = 1'($urandom_range(0, 1));
            e = d ? model_dec(b) : model_enc(b);
            send(b, d, e, w);
            if (i > 0) check("throughput wait", 128'(w), 128'd75);
        end
        wait_drain();

        load_keys({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            b = rand_blk(); d = 1'($urandom_range(0, 1));
            e = d ? model_dec(b) : model_enc(b);
            send(b, d, e, w);
        end
        wait_drain();

        // Abort by key regeneration at cycle 40 of RUN
        b = rand_blk();
        send(b, 1'b0, model_enc(b), w);
        tick(39);
        key_compute_start = 1'b1;
        @(negedge clk);
        check("key_rd_en in abort cycle", 128'(key_rd_en), 128'd1);
        cnt_abort = int'(abort_err);
        @(posedge clk); #1;
        key_compute_start = 1'b0;
        @(negedge clk);
        check("key_rd_en after abort", 128'(key_rd_en), 128'd0);
        cnt_abort += int'(abort_err);
        cnt_ov = 0; cnt_rdy = 0; cnt_rd = 0;
        repeat (100) begin
            @(negedge clk);
            cnt_abort += int'(abort_err);
            cnt_ov    += int'(out_valid);
            cnt_rdy   += int'(in_ready);
            cnt_rd    += int'(key_rd_en);
        end
        check("abort_err pulse count", 128'(cnt_abort), 128'd1);
        check("out_valid after abort", 128'(cnt_ov), 128'd0);
        check("in_ready after abort", 128'(cnt_rdy), 128'd0);
        check("key_rd_en after abort window", 128'(cnt_rd), 128'd0);
        exp_q.delete();
        addr_q.delete();
        load_keys(KAT_KEY);
        send(KAT_PT, 1'b0, KAT_CT, w);
        wait_drain();

        // Output backpressure for 20 cycles
        out_ready = 1'b0;
        b = rand_blk(); d = 1'($urandom_range(0, 1));
        e = d ? model_dec(b) : model_enc(b);
        send(b, d, e, w);
        w = 0;
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        check("out_valid under backpressure", 128'(out_valid), 128'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_block !== e || in_ready !== 1'b0) bad++;
        end
        check("backpressure hold", 128'(bad), 128'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        check("out_valid after accept", 128'(out_valid), 128'd0);

        // Asynchronous reset at cycle 30 of RUN
        send(KAT_PT, 1'b0, KAT_CT, w);
        tick(29);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-run reset ctrl", 128'({in_ready, out_valid, abort_err, key_rd_en, key_addr}), 128'd0);
        check("mid-run reset out_block", out_block, 128'd0);
        exp_q.delete();
        addr_q.delete();
        tick(3);
        rst_n = 1'b1;
        cnt_rdy = 0;
        repeat (5) begin
            @(negedge clk);
            cnt_rdy += int'(in_ready);
        end
        check("keys_ok cleared by reset", 128'(cnt_rdy), 128'd0);
        @(posedge clk); #1;
        key_mem_full = 1'b1;
        tick(1);
        key_mem_full = 1'b0;
        send(KAT_PT, 1'b0, KAT_CT, w);
        wait_drain();

        tick(5);
        check("address queue empty", 128'(addr_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
Sequences one Simon128/256 block operation (encrypt or decrypt) against the subkey memory filled by the key scheduler. It accepts a 128b block over a valid/ready handshake and streams 72 subkey reads through the memory's read port, in forward or reverse order. It applies one Simon round per returned subkey and presents the result over a valid/ready output. It sits between the host/AXI-stream wrapper and key_schedule, and owns key_rd_en/key_addr.

Parameters:
ROUNDS, 72, number of rounds and subkeys (addresses 0..ROUNDS-1)
KEY_LAT, 2, cycles from key_rd_en/key_addr to key_data_vld/key_data
WORD, 64, Simon word width n
ADDR_W, 9, key memory address width

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input block valid
in_ready  out  1  controller can accept a block
in_decrypt  in  1  sampled with the block: 1 = decrypt, 0 = encrypt
in_block  in  128  {x[127:64], y[63:0]}
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts the result
out_block  out  128  {x, y} result
abort_err  out  1  one-cycle pulse: operation aborted by a key regeneration
key_compute_start  in  1  observed copy of the scheduler start strobe
key_mem_full  in  1  scheduler reports the subkey memory is complete
key_rd_en  out  1  subkey read request
key_addr  out  ADDR_W  subkey address
key_data  in  WORD  subkey read data
key_data_vld  in  1  key_data valid (KEY_LAT after the request)

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_block=0, abort_err=0, key_rd_en=0, key_addr=0, keys_ok=0, state=IDLE.
- keys_ok flag: set on key_mem_full=1; cleared on key_compute_start=1. Start takes priority when both are asserted in the same cycle.
- in_ready = (state==IDLE) && keys_ok && !key_compute_start.
- States:
  - IDLE: on in_valid&&in_ready, latch x, y and the mode, clear the issue and receive counters, go to RUN.
  - RUN: drive key_rd_en=1 every cycle. key_addr = issue_cnt (encrypt) or ROUNDS-1-issue_cnt (decrypt), upper address bits 0. After ROUNDS issues go to DRAIN.
  - DRAIN: key_rd_en=0. Wait until the receive count reaches ROUNDS, then go to DONE.
  - DONE: out_valid=1 with out_block stable. On out_ready go to IDLE. A new block can be accepted in the cycle after the handshake.
- Round update, applied on each key_data_vld in RUN or DRAIN, with f(v) = (rol1 v & rol8 v) ^ rol2 v:
  - encrypt: x <= y ^ f(x) ^ k; y <= x
  - decrypt: x <= y; y <= x ^ f(y) ^ k
- Timing: handshake at cycle 0, reads at cycles 1..72, data at cycles 3..74, out_valid first high at cycle 75. Latency is 75 cycles. Throughput is one block per 76 cycles when out_ready is held high.
- key_data_vld outside RUN/DRAIN is ignored. No state change.
- Abort: key_compute_start in RUN, DRAIN or DONE:
  - drop the operation, force out_valid=0 and key_rd_en=0, go to IDLE;
  - pulse abort_err for one cycle;
  - discard in-flight key_data_vld returns (use a KEY_LAT-deep drop counter);
  - the block is lost and is not retried.
- key_compute_start in IDLE only clears keys_ok. No abort_err.
- Counters are 7b and saturate at ROUNDS. Addresses never exceed ROUNDS-1.
- rst_n asserted mid-operation clears everything asynchronously. Deassertion must be synchronised externally.

Decomposition:
- simon_pkg: the ROUNDS, WORD and KEY_LAT constants; a state_t enum {IDLE, RUN, DRAIN, DONE}; functions rol(v, s) and simon_f(v). key_schedule reuses the same constants.
- One sub-module, simon_round: a combinational single round with mode input, 128b in, 64b key, 128b out. Reusable by an unrolled datapath later.

Test Plan:
- Encrypt known answer:
  - key 0x1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100 (k0 = 0x0706050403020100), wait for key_mem_full;
  - block 0x74206e69206d6f6f_6d69732061207369 -> out_block 0x8d2b5579afc8a3a0_3bf72a87efe7b868;
  - out_valid at cycle 75; addresses 0..71 contiguous.
- Decrypt the same ciphertext, in_decrypt=1 -> plaintext recovered; addresses 71 down to 0.
- Before key_mem_full, in_valid=1 -> in_ready=0, no key_rd_en. After key_mem_full, in_ready rises the next cycle.
- key_compute_start pulsed at cycle 40 of RUN:
  - abort_err single pulse, out_valid stays 0, key_rd_en drops the next cycle;
  - both late returns are ignored; in_ready=0 until the next key_mem_full.
- Backpressure: out_ready=0 for 20 cycles -> out_valid and out_block held stable, in_ready=0; completes on out_ready=1.
- rst_n asserted at cycle 30 of RUN:
  - all outputs go to reset values immediately;
  - after release, keys_ok=0 until key_mem_full, then a full encrypt passes.
